// File: rtl/conv_addr_pkg.sv
// conv_addr_pkg: shared FSM state type and window-geometry helpers for the conv address generator
package conv_addr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int out_dim(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

    function automatic int last_col(input int w, input int k, input int s);
        return (out_dim(w, k, s) - 1) * s + k - 1;
    endfunction

    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/conv_wrap_counter.sv
// conv_wrap_counter: 0..MAX counter that wraps on inc and flags its terminal value
module conv_wrap_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = count == W'(MAX);

    // step on inc, fold back to zero after the terminal value
    always_ff @(posedge clk) begin
        if (reset || clr) count <= '0;
        else if (inc) count <= wrap ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// conv_window_addr_gen: banded KxK strided-window read-address generator with tap hold and back-pressure
module conv_window_addr_gen
    import conv_addr_pkg::*;
#(
    parameter int IMG_W  = 9,
    parameter int IMG_H  = 16,
    parameter int NUM_CH = 1,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 2,
    parameter int TAPS   = 3,
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [KSIZE*ADDR_W-1:0]   rd_addr,
    output logic [$clog2(TAPS):0]     tap_idx,
    output logic                      win_last,
    output logic                      band_last,
    output logic                      busy,
    output logic                      done
);

    localparam int OUT_H    = out_dim(IMG_H, KSIZE, STRIDE);
    localparam int LAST_COL = last_col(IMG_W, KSIZE, STRIDE);
    localparam int PLANE    = IMG_W * IMG_H;
    localparam int TW       = cnt_w(TAPS - 1);
    localparam int CW       = cnt_w(LAST_COL);
    localparam int BW       = cnt_w(OUT_H - 1);
    localparam int HW       = cnt_w(NUM_CH - 1);

    if (NUM_CH * IMG_W * IMG_H > 2 ** ADDR_W) begin : g_addr_too_narrow
        $error("ADDR_W too small for NUM_CH*IMG_W*IMG_H");
    end

    state_t                    r_state;
    logic [KSIZE*ADDR_W-1:0]   r_rd_addr;
    logic [KSIZE*ADDR_W-1:0]   w_addr_n;
    logic [TW-1:0]             w_tap;
    logic [CW-1:0]             w_col, w_col_n;
    logic [BW-1:0]             w_band, w_band_n;
    logic [HW-1:0]             w_ch, w_ch_n;
    logic                      w_run, w_fire, w_clr, w_last;
    logic                      w_tap_wrap, w_col_wrap, w_band_wrap, w_ch_wrap;
    logic                      w_col_inc, w_band_inc, w_ch_inc;

    assign w_run      = r_state == RUN;
    assign w_fire     = w_run && out_ready;
    assign w_clr      = reset || !w_run;
    assign w_col_inc  = w_fire && w_tap_wrap;
    assign w_band_inc = w_col_inc && w_col_wrap;
    assign w_ch_inc   = w_band_inc && w_band_wrap;
    assign w_last     = w_ch_inc && w_ch_wrap;

    conv_wrap_counter #(.MAX(TAPS - 1), .W(TW)) u_tap (
        .clk(clk), .reset(reset), .clr(!w_run), .inc(w_fire), .count(w_tap), .wrap(w_tap_wrap)
    );
    conv_wrap_counter #(.MAX(LAST_COL), .W(CW)) u_col (
        .clk(clk), .reset(reset), .clr(!w_run), .inc(w_col_inc), .count(w_col), .wrap(w_col_wrap)
    );
    conv_wrap_counter #(.MAX(OUT_H - 1), .W(BW)) u_band (
        .clk(clk), .reset(reset), .clr(!w_run), .inc(w_band_inc), .count(w_band), .wrap(w_band_wrap)
    );
    conv_wrap_counter #(.MAX(NUM_CH - 1), .W(HW)) u_ch (
        .clk(clk), .reset(reset), .clr(!w_run), .inc(w_ch_inc), .count(w_ch), .wrap(w_ch_wrap)
    );

    // the address register tracks the counters' next values so rd_addr lines up with the current beat
    assign w_col_n  = w_clr ? '0 : w_col_inc  ? (w_col_wrap  ? '0 : w_col  + 1'b1) : w_col;
    assign w_band_n = w_clr ? '0 : w_band_inc ? (w_band_wrap ? '0 : w_band + 1'b1) : w_band;
    assign w_ch_n   = w_clr ? '0 : w_ch_inc   ? (w_ch_wrap   ? '0 : w_ch   + 1'b1) : w_ch;

    // one row address per kernel row, all sharing the column and channel base
    always_comb begin
        w_addr_n = '0;
        for (int k = 0; k < KSIZE; k++)
            w_addr_n[k*ADDR_W +: ADDR_W] = ADDR_W'(int'(w_ch_n) * PLANE
                + (int'(w_band_n) * STRIDE + k) * IMG_W + int'(w_col_n));
    end

    // register next-beat addresses
    always_ff @(posedge clk) begin
        r_rd_addr <= w_addr_n;
    end

    // IDLE -> RUN on start, RUN -> DONE when the final beat fires, DONE lasts one cycle
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= (r_state == IDLE) ? (start ? RUN : IDLE)
                      : (r_state == RUN) ? ((w_fire && w_last) ? DONE : RUN)
                      : IDLE;
    end

    assign out_valid = w_run;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign rd_addr   = r_rd_addr;
    assign tap_idx   = ($clog2(TAPS) + 1)'(w_tap);
    assign win_last  = w_run && (int'(w_col) >= KSIZE - 1)
                       && ((int'(w_col) - (KSIZE - 1)) % STRIDE == 0);
    assign band_last = w_run && (w_col == CW'(LAST_COL));

endmodule
